game_ctrl: RTL and testbench
============================

# game_ctrl

Game-control stage downstream of the obstacle scroller. It consumes the three obstacle positions and the dino's current row, and detects dino/obstacle overlap on the 16-column LED matrix. It runs the start/run/over state machine, keeps a 4-digit BCD score and high score, and drives `flag_restart` back into the obstacle scroller.

## Interface
- `DINO_COL`, 2: matrix column the dino occupies (0..15).
- `LENGTH`, 51: obstacle track length; position `LENGTH-1` is the wrap slot.
- `RESTART_HOLD`, 50_000_000: clk cycles `flag_restart` is held in RESTART. Must exceed one period of the slowest obstacle clock.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_btn` in 1: start/restart button, already synchronised and debounced, level.
- `score_tick` in 1: one-clk strobe; score += 1 while RUN.
- `ob1` in 8: box position; columns ob1 and ob1+1, rows 0–1.
- `ob2` in 8: vertical-line position; column ob2, rows 0–1.
- `ob3` in 8: bird position; columns ob3 and ob3+1, row 3.
- `dino_row` in 3: dino bottom row; dino occupies dino_row and dino_row+1.
- `flag_restart` out 1: high = obstacle scroller held at start positions.
- `game_over` out 1: high in OVER.
- `running` out 1: high in RUN.
- `score` out 16: 4 BCD digits, [15:12] most significant.
- `hiscore` out 16: 4 BCD digits (see Configuration).

## Operation
- States: IDLE, RESTART, RUN, OVER.
- Reset values: state IDLE; `flag_restart` 1; `game_over` 0; `running` 0; `score` 0; `hiscore` 0; hold counter 0; start edge register 0.
- Start edge: `start_btn` high this cycle and low the previous cycle. A held button produces one edge only.
- IDLE: `flag_restart`=1. On start edge, go to RESTART.
- RESTART: `flag_restart`=1. Clear `score` on entry. Count clk cycles; after RESTART_HOLD cycles, go to RUN. Start edges are ignored here.
- RUN: `flag_restart`=0 and `running`=1. On `score_tick`, do a BCD increment with carry across digits; saturate at 9999. On registered collision, go to OVER.
- OVER: `game_over`=1 and `flag_restart`=0. `score` is frozen. On start edge, go to RESTART.
- Column occupancy for position p with a 2-wide obstacle:
  - p ≤ 14: columns p and p+1.
  - p == 15: column 15 only.
  - p == LENGTH-1: column 0 only.
  - Otherwise: nothing.
- Column occupancy for ob2: column ob2 if ob2 ≤ 15, else nothing.
- Ground hit: DINO_COL is occupied by ob1 or ob2, and dino_row ≤ 1.
- Bird hit: DINO_COL is occupied by ob3, and dino_row ∈ {2,3}.
- `collide` = ground hit OR bird hit. It is computed combinationally from the inputs and registered once.
- A collision while not in RUN is ignored.
- A `score_tick` and a collision in the same cycle: the score increments, then the state goes to OVER.

## Timing
- Collision path: inputs → `collide_q` in 1 clk → state OVER and `game_over`=1 at the next edge. Total 2 clk from the overlapping inputs.
- Start edge: edge detected at edge n, state RESTART at edge n+1.
- RESTART → RUN takes exactly RESTART_HOLD clk after entry. `flag_restart` falls in the same cycle `running` rises.
- Score: updates at the clk edge that samples `score_tick`.
- Reset mid-operation: all registers return to reset values immediately (asynchronous); deassertion is synchronous to `clk`.
- Outputs are registered with no combinational input→output paths.

## Configuration
- `GAME_CTRL_HISCORE_EN` defined:
  - On the RUN→OVER transition, `hiscore` loads `score` if `score` > `hiscore` (BCD compare, equivalent to binary compare on packed digits).
  - `hiscore` survives RESTART and clears only on reset.
- Undefined: `hiscore` is tied to 0 and no register is inferred.

## Structure
- `game_pkg` holds:
  - the state enum;
  - LENGTH;
  - obstacle row constants (ground rows 0–1, bird row 3);
  - the BCD digit width.
- Sub-module `bcd_counter4`: 4-digit BCD counter with `clr`, `inc`, saturation at 9999, and async active-low reset. It is instantiated for `score`.
- Occupancy and collision logic stays inline as a function.

## Test plan
- Reset, then release with `start_btn`=0 → `flag_restart`=1, state IDLE, `score`=0x0000, `game_over`=0.
- RESTART_HOLD=8; start edge at cycle 10 → RESTART at 11, `running`=1 at 19, `flag_restart`=0 at 19.
- RUN, ob1=2, dino_row=0, DINO_COL=2 → `game_over`=1 two clk later. Same positions with dino_row=3 → no collision. ob1=LENGTH-1 with DINO_COL=0 → collision.
- RUN, ob3=1, dino_row=2 → OVER. ob3=1, dino_row=5 → no collision.
- 10000 `score_tick` pulses in RUN → `score`=0x9999 held. 0x0099 plus one tick → 0x0100.
- `GAME_CTRL_HISCORE_EN`:
  - Game 1 scores 0x0042 → `hiscore`=0x0042.
  - Game 2 scores 0x0017 → `hiscore` stays 0x0042.
  - Reset → 0x0000.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game-control stage.
//   - game_state_e : start/run/over state machine encoding
//   - OB_LENGTH    : obstacle track length (position OB_LENGTH-1 is the wrap slot)
//   - row constants: ground obstacles sit on rows 0..1, the bird on row 3
//   - BCD geometry : digit width and digit count of score/hiscore
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTART = 2'd1,
    ST_RUN     = 2'd2,
    ST_OVER    = 2'd3
  } game_state_e;

  localparam int unsigned OB_LENGTH     = 51;
  localparam int unsigned MATRIX_COLS   = 16;

  localparam int unsigned GROUND_ROW_LO = 0;
  localparam int unsigned GROUND_ROW_HI = 1;
  localparam int unsigned BIRD_ROW      = 3;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_DIGITS    = 4;

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: signal bundle between the obstacle scroller / dino logic and
// the game-control stage.
// There is no valid/ready handshake on this bundle: start_btn is a level,
// score_tick is a one-clk strobe, obstacle and dino positions are sampled
// every clk, and all outputs are levels that are valid every cycle.
//   slave  modport : used by game_ctrl (inputs in, status/score out)
//   master modport : used by whoever drives the stage
interface game_ctrl_if;
  logic        start_btn;
  logic        score_tick;
  logic [7:0]  ob1;
  logic [7:0]  ob2;
  logic [7:0]  ob3;
  logic [2:0]  dino_row;
  logic        flag_restart;
  logic        game_over;
  logic        running;
  logic [15:0] score;
  logic [15:0] hiscore;

  modport slave (
    input  start_btn, score_tick, ob1, ob2, ob3, dino_row,
    output flag_restart, game_over, running, score, hiscore
  );

  modport master (
    output start_btn, score_tick, ob1, ob2, ob3, dino_row,
    input  flag_restart, game_over, running, score, hiscore
  );
endinterface

// File: rtl/game_ctrl_bcd_counter4.sv
// bcd_counter4: 4-digit packed BCD counter, [15:12] most significant.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   clr_i      : synchronous clear, wins over inc_i
//   inc_i      : add one with decimal carry; holds at 9999
//   count_o    : registered count
//   next_o     : value the count takes at the next clk edge
module bcd_counter4
  import game_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr_i,
  input  logic                              inc_i,
  output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] count_o,
  output logic [BCD_DIGITS*BCD_DIGIT_W-1:0] next_o
);

  localparam int unsigned W = BCD_DIGITS * BCD_DIGIT_W;
  localparam logic [W-1:0] BCD_MAX = {BCD_DIGITS{4'd9}};

  logic [W-1:0] count_q, count_d;
  logic         carry;

  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != BCD_MAX)) begin
      // Ripple the +1 upward: a 9 wraps to 0 and passes the carry on.
      carry = 1'b1;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
        if (carry) begin
          if (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
            count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
          end else begin
            count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game-control stage downstream of the obstacle scroller.
// Detects dino/obstacle overlap on the 16-column matrix, runs the
// IDLE/RESTART/RUN/OVER state machine, keeps a BCD score (and optional
// high score) and drives flag_restart back to the scroller.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : game_ctrl_if.slave (start_btn, score_tick, ob1..ob3,
//                dino_row in; flag_restart, game_over, running, score,
//                hiscore out)
//   state_o    : current FSM state, for observation
// Parameters: DINO_COL (dino column), LENGTH (track length, LENGTH-1 is the
// wrap slot), RESTART_HOLD (clk cycles spent in RESTART).
// Optional feature macro: GAME_CTRL_HISCORE_EN keeps a high score that is
// updated on every RUN->OVER transition; without it hiscore is constant 0.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DINO_COL     = 2,
  parameter int unsigned LENGTH       = OB_LENGTH,
  parameter int unsigned RESTART_HOLD = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  game_ctrl_if.slave  bus,
  output game_state_e state_o
);

  localparam int unsigned  HOLD_W    = $clog2(RESTART_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESTART_HOLD - 1);
  localparam logic [7:0]   WRAP_POS  = 8'(LENGTH - 1);
  localparam logic [7:0]   DINO_C    = 8'(DINO_COL);
  localparam logic [7:0]   LAST_COL  = 8'(MATRIX_COLS - 1);

  // Does a 2-wide obstacle at position p cover column col? The wrap slot
  // shows only its trailing half in column 0; column 15 shows only the
  // leading half.
  function automatic logic occ2(input logic [7:0] p, input logic [7:0] col);
    logic hit;
    hit = 1'b0;
    if (p < LAST_COL)       hit = (col == p) || (col == p + 8'd1);
    else if (p == LAST_COL) hit = (col == LAST_COL);
    else if (p == WRAP_POS) hit = (col == 8'd0);
    return hit;
  endfunction

  function automatic logic occ1(input logic [7:0] p, input logic [7:0] col);
    return (p <= LAST_COL) && (col == p);
  endfunction

  // Dino spans rows dino_row and dino_row+1.
  function automatic logic collide_f(input logic [7:0] o1, input logic [7:0] o2,
                                     input logic [7:0] o3, input logic [2:0] row);
    logic ground_hit, bird_hit;
    ground_hit = (occ2(o1, DINO_C) || occ1(o2, DINO_C)) && (row <= 3'(GROUND_ROW_HI));
    bird_hit   = occ2(o3, DINO_C) &&
                 ((row == 3'(BIRD_ROW - 1)) || (row == 3'(BIRD_ROW)));
    return ground_hit || bird_hit;
  endfunction

  game_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              start_prev_q, start_edge_q, collide_q;
  logic              score_clr, score_inc;
  logic [15:0]       score_q, score_next;

  // Registered edge: a rising edge seen at edge n acts on the FSM at edge n+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
      collide_q    <= 1'b0;
    end else begin
      start_prev_q <= bus.start_btn;
      start_edge_q <= bus.start_btn & ~start_prev_q;
      collide_q    <= collide_f(bus.ob1, bus.ob2, bus.ob3, bus.dino_row);
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    score_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge_q) begin
          state_d   = ST_RESTART;
          hold_d    = '0;
          score_clr = 1'b1;
        end
      end
      ST_RESTART: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      ST_RUN: begin
        if (collide_q) state_d = ST_OVER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tick in the collision cycle still counts: score_inc only looks at
  // the current state, not the next one.
  assign score_inc = (state_q == ST_RUN) && bus.score_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  bcd_counter4 u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .count_o (score_q),
    .next_o  (score_next)
  );

`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] hiscore_q, hiscore_d;

  // Packed BCD orders the same as binary, so a plain compare works. The
  // candidate is score_next so a tick in the final cycle is included.
  always_comb begin
    hiscore_d = hiscore_q;
    if ((state_q == ST_RUN) && (state_d == ST_OVER) && (score_next > hiscore_q))
      hiscore_d = score_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hiscore_q <= '0;
    else        hiscore_q <= hiscore_d;
  end

  assign bus.hiscore = hiscore_q;
`else
  logic unused_next;
  assign unused_next = ^score_next;
  assign bus.hiscore = '0;
`endif

  // All outputs decode registered state only.
  assign bus.flag_restart = (state_q == ST_IDLE) || (state_q == ST_RESTART);
  assign bus.running      = (state_q == ST_RUN);
  assign bus.game_over    = (state_q == ST_OVER);
  assign bus.score        = score_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
  import game_pkg::*;

  localparam int HOLD = 8;
  localparam int SAFE = 40;  // off-matrix, not the wrap slot

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_ctrl_if if_a ();
  game_ctrl_if if_b ();
  game_state_e state_a, state_b;

  game_ctrl #(.DINO_COL(2), .LENGTH(OB_LENGTH), .RESTART_HOLD(HOLD)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .state_o(state_a));

  // Second instance with the dino in column 0 to reach the wrap slot.
  game_ctrl #(.DINO_COL(0), .LENGTH(OB_LENGTH), .RESTART_HOLD(HOLD)) u_dut_col0 (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .state_o(state_b));

  assign if_b.start_btn  = if_a.start_btn;
  assign if_b.score_tick = if_a.score_tick;
  assign if_b.ob1        = if_a.ob1;
  assign if_b.ob2        = if_a.ob2;
  assign if_b.ob3        = if_a.ob3;
  assign if_b.dino_row   = if_a.dino_row;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (dino column 2) ----------------
  function automatic bit covers2(int p, int c);
    if (p == OB_LENGTH - 1) return c == 0;
    return (p < 16) && (c < 16) && (c == p || c == p + 1);
  endfunction

  function automatic bit model_collide(int col, int o1, int o2, int o3, int row);
    bit hit = 0;
    for (int r = row; r <= row + 1; r++) begin
      if ((r == 0 || r == 1) && (covers2(o1, col) || (o2 < 16 && o2 == col))) hit = 1;
      if (r == 3 && covers2(o3, col)) hit = 1;
    end
    return hit;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int next_score(int s, bit tick);
    return (tick && s < 9999) ? s + 1 : s;
  endfunction

  game_state_e m_st;
  int m_hold, m_score, m_hi;
  bit m_prev, m_edge, m_coll;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= ST_IDLE; m_hold <= 0; m_score <= 0; m_hi <= 0;
      m_prev <= 0; m_edge <= 0; m_coll <= 0;
    end else begin
      case (m_st)
        ST_IDLE, ST_OVER: if (m_edge) begin
          m_st <= ST_RESTART; m_hold <= 0; m_score <= 0;
        end
        ST_RESTART: begin
          m_hold <= m_hold + 1;
          if (m_hold + 1 == HOLD) m_st <= ST_RUN;
        end
        default: begin
          m_score <= next_score(m_score, if_a.score_tick);
          if (m_coll) begin
            m_st <= ST_OVER;
`ifdef GAME_CTRL_HISCORE_EN
            if (next_score(m_score, if_a.score_tick) > m_hi)
              m_hi <= next_score(m_score, if_a.score_tick);
`endif
          end
        end
      endcase
      m_coll <= model_collide(2, int'(if_a.ob1), int'(if_a.ob2), int'(if_a.ob3), int'(if_a.dino_row));
      m_edge <= if_a.start_btn && !m_prev;
      m_prev <= if_a.start_btn;
    end
  end

  // ---------------- scoreboard: every cycle out of reset ----------------
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      exp_q.push_back(to_bcd(m_score));
      check("m_state",   32'(state_a), 32'(m_st));
      check("m_flag",    32'(if_a.flag_restart), 32'(m_st == ST_IDLE || m_st == ST_RESTART));
      check("m_running", 32'(if_a.running), 32'(m_st == ST_RUN));
      check("m_over",    32'(if_a.game_over), 32'(m_st == ST_OVER));
      check("m_score",   32'(if_a.score), 32'(exp_q.pop_front()));
      check("m_hiscore", 32'(if_a.hiscore), 32'(to_bcd(m_hi)));
    end
  end

  // ---------------- driver tasks (each ends just after a negedge) ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    if_a.score_tick = 1'b1;
    repeat (n) @(negedge clk);
    if_a.score_tick = 1'b0;
  endtask

  task automatic restart_game();
    bit ok = 0;
    if_a.start_btn = 1'b1;
    @(negedge clk);
    if_a.start_btn = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = if_a.running;
    end
    check("restart_reaches_run", 32'(ok), 32'd1);
  endtask

  task automatic crash();
    if_a.ob1 = 8'd2;
    if_a.dino_row = 3'd0;
    repeat (2) @(negedge clk);
    check("crash_over", 32'(if_a.game_over), 32'd1);
    if_a.ob1 = 8'(SAFE);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    if_a.start_btn = 0; if_a.score_tick = 0;
    if_a.ob1 = 8'(SAFE); if_a.ob2 = 8'(SAFE); if_a.ob3 = 8'(SAFE); if_a.dino_row = 0;
    do_reset();
    check("rst_state", 32'(state_a), 32'(ST_IDLE));
    check("rst_flag",  32'(if_a.flag_restart), 32'd1);
    check("rst_score", 32'(if_a.score), 32'h0000);
    check("rst_over",  32'(if_a.game_over), 32'd0);

    // Start edge sampled at edge n, RESTART at n+1, RUN HOLD edges later.
    if_a.start_btn = 1'b1;
    @(negedge clk); check("edge_still_idle", 32'(state_a), 32'(ST_IDLE));
    @(negedge clk); check("restart_entry", 32'(state_a), 32'(ST_RESTART));
    repeat (HOLD - 1) @(negedge clk);
    check("hold_not_done", 32'(if_a.running), 32'd0);
    @(negedge clk);
    check("run_after_hold", 32'(if_a.running), 32'd1);
    check("flag_falls",     32'(if_a.flag_restart), 32'd0);

    // Wrap slot covers column 0 only: col-0 instance hits, col-2 does not.
    if_a.ob1 = 8'(OB_LENGTH - 1);
    @(negedge clk); check("wrap_latency", 32'(if_b.game_over), 32'd0);
    @(negedge clk); check("wrap_col0_hit", 32'(if_b.game_over), 32'd1);
    check("wrap_col0_state", 32'(state_b), 32'(ST_OVER));
    check("wrap_col2_miss", 32'(if_a.game_over), 32'd0);

    // Ground box over the dino column with the dino jumping high: no hit.
    if_a.ob1 = 8'd2; if_a.dino_row = 3'd3;
    repeat (3) @(negedge clk); check("box_jump_clear", 32'(if_a.game_over), 32'd0);
    if_a.dino_row = 3'd0;
    @(negedge clk); check("box_latency", 32'(if_a.game_over), 32'd0);
    @(negedge clk); check("box_hit", 32'(if_a.game_over), 32'd1);
    // start_btn held since the first edge: no second edge, stays OVER.
    repeat (3) @(negedge clk); check("held_btn_one_edge", 32'(state_a), 32'(ST_OVER));
    if_a.start_btn = 1'b0; if_a.ob1 = 8'(SAFE);
    @(negedge clk);

    // Bird at columns 1..2.
    restart_game();
    if_a.ob3 = 8'd1; if_a.dino_row = 3'd5;
    repeat (3) @(negedge clk); check("bird_clear", 32'(if_a.game_over), 32'd0);
    if_a.dino_row = 3'd2;
    repeat (2) @(negedge clk); check("bird_hit", 32'(if_a.game_over), 32'd1);
    if_a.ob3 = 8'(SAFE); if_a.dino_row = 3'd0;

    // Saturation at 9999.
    restart_game();
    check("score_cleared", 32'(if_a.score), 32'h0000);
    ticks(10000);
    @(negedge clk); check("sat_9999", 32'(if_a.score), 32'h9999);
    ticks(5);
    @(negedge clk); check("sat_hold", 32'(if_a.score), 32'h9999);
    crash();

    // Decimal carry, then a tick in the collision cycle.
    restart_game();
    ticks(99);
    check("bcd_0099", 32'(if_a.score), 32'h0099);
    ticks(1);
    check("bcd_0100", 32'(if_a.score), 32'h0100);
    if_a.ob1 = 8'd2;
    @(negedge clk);
    if_a.score_tick = 1'b1;
    @(negedge clk);
    if_a.score_tick = 1'b0; if_a.ob1 = 8'(SAFE);
    check("tick_and_crash_over",  32'(if_a.game_over), 32'd1);
    check("tick_and_crash_score", 32'(if_a.score), 32'h0101);
    repeat (2) @(negedge clk); check("over_frozen", 32'(if_a.score), 32'h0101);

`ifdef GAME_CTRL_HISCORE_EN
    do_reset();
    restart_game(); ticks(42); crash();
    check("hi_game1", 32'(if_a.hiscore), 32'h0042);
    restart_game(); ticks(17); crash();
    check("hi_game2_score", 32'(if_a.score), 32'h0017);
    check("hi_game2_keep",  32'(if_a.hiscore), 32'h0042);
    do_reset();
    check("hi_reset", 32'(if_a.hiscore), 32'h0000);
`else
    check("hi_tied_zero", 32'(if_a.hiscore), 32'h0000);
`endif

    // Asynchronous reset in the middle of a game.
    restart_game(); ticks(3);
    #2 rst_n = 1'b0;
    #1 check("async_rst_state", 32'(state_a), 32'(ST_IDLE));
    check("async_rst_score", 32'(if_a.score), 32'h0000);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout reached at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
